i2c_target_regs: RTL and testbench
==================================

I2C_TARGET_REGS -- requirements
Module: i2c_target_regs

Interface
REQ-001 SHALL have parameter TARGET_ADDR, default 7'h3C: the 7-bit bus address this target answers to.
REQ-002 SHALL have parameter NUM_REGS, default 4: register-file depth; legal values are 2, 4 and 8.
REQ-003 SHALL have port i_clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port scl_in, input, 1 bit: raw bus SCL, asynchronous to i_clk.
REQ-006 SHALL have port sda_in, input, 1 bit: raw bus SDA, asynchronous to i_clk.
REQ-007 SHALL have port sda_out, output, 1 bit: SDA drive value, tied to 0 (open-drain).
REQ-008 SHALL have port sda_out_en, output, 1 bit: 1 = pull SDA low, 0 = release SDA.
REQ-009 SHALL have port reg_out, output, NUM_REGS*8 bits: flat register-file contents, with reg[i] at bits [8i+7:8i].
REQ-010 SHALL have port wr_pulse, output, 1 bit: a 1-cycle strobe each time a register is written from the bus.
REQ-011 SHALL have port busy, output, 1 bit: high from an address match until STOP or a return to IDLE.

Function
REQ-012 SHALL pass scl_in and sda_in through 2-flop synchronizers and derive rise/fall edges from the synchronized values only.
REQ-013 SHALL detect START as a synced SDA fall while synced SCL is high, and STOP as a synced SDA rise while synced SCL is high; both are detected in every state.
REQ-014 SHALL have states IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA and RDATA_ACK.
REQ-015 SHALL move from any state to ADDR on START (including a repeated START), with the bit counter cleared.
REQ-016 SHALL move from any state to IDLE on STOP, releasing SDA and clearing busy.
REQ-017 SHALL sample bus bits on the synced SCL rising edge, MSB first, and change sda_out_en only on the cycle after a synced SCL falling edge.
REQ-018 SHALL treat ADDR as 7 address bits plus 1 R/W bit; on a match it SHALL drive ACK (sda_out_en=1) during the 9th clock, otherwise it SHALL release SDA and return to IDLE.
REQ-019 SHALL, after a write-address ACK, receive a byte into the pointer register ptr (ptr modulo NUM_REGS) and ACK it.
REQ-020 SHALL write each subsequent received byte to reg[ptr], ACK it, and pulse wr_pulse on the ACK falling edge.
REQ-021 SHALL, after a read-address ACK, drive reg[ptr] MSB first (sda_out_en = ~bit) and release SDA for the 9th clock.
REQ-022 SHALL on a master ACK (SDA low on the 9th rising edge) load the next byte, and on a master NACK release SDA and wait in IDLE for STOP or START.
REQ-023 SHALL wrap the pointer from NUM_REGS-1 to 0.
REQ-024 SHALL, if START and STOP coincide with an SCL edge in the same cycle, let START/STOP take priority over the data bit.

Reset
REQ-025 SHALL on reset assertion immediately force state=IDLE, sda_out_en=0, sda_out=0, wr_pulse=0, busy=0, ptr=0, all registers=0, and synchronizers=1 (idle bus).
REQ-026 SHALL release SDA immediately on reset asserted mid-transfer, and SHALL ignore the remainder of that frame until the next START.

Configuration
REQ-027 SHALL, with I2C_TARGET_AUTOINC_EN defined, increment ptr after every data byte written or read.
REQ-028 SHALL, without I2C_TARGET_AUTOINC_EN, hold ptr fixed for the whole transaction, so repeated bytes hit the same register.

Structure
REQ-029 SHALL define the state enum, the address/R-W bit positions and the ACK/NACK constants in package i2c_pkg.
REQ-030 SHALL place the synchronizers and the START/STOP/SCL-edge detector in sub-module i2c_bus_sync.

Verification
REQ-031 SHALL cover: write addr 0x3C, ptr 0x01, data 0xA5 -> ACK on all 3 bytes, reg[1]=0xA5, one wr_pulse.
REQ-032 SHALL cover: write addr 0x3C, ptr 0x03, then read 2 bytes (ACK, NACK) after a repeated START -> returns reg[3], then reg[0] with AUTOINC (reg[3] twice without it).
REQ-033 SHALL cover: addr 0x3D -> SDA released on the 9th clock, busy stays 0, no register changes.
REQ-034 SHALL cover: write ptr 0x02 then STOP after 4 data bits -> reg[2] unchanged, state IDLE, busy 0.
REQ-035 SHALL cover: reset asserted during a read byte while driving SDA low -> sda_out_en=0 in the same cycle, all regs 0.
REQ-036 SHALL cover: write ptr 0x05 with NUM_REGS=4 -> data lands in reg[1].

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C register target: FSM states, byte field
// positions, bus ACK levels and the synchronized bus-event payload.
package i2c_pkg;

    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned BIT_CNT_W = 4;

    // Address byte layout: 7-bit address in [7:1], R/W in [0] (1 = read)
    localparam int unsigned ADDR_MSB = 7;
    localparam int unsigned ADDR_LSB = 1;
    localparam int unsigned RW_BIT   = 0;

    localparam logic ACK_LVL  = 1'b0;
    localparam logic NACK_LVL = 1'b1;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RDATA_ACK
    } state_t;

    typedef struct packed {
        logic start;
        logic stop;
        logic scl_rise;
        logic scl_fall;
        logic sda;
    } bus_evt_t;

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronizes raw SCL/SDA into i_clk and emits registered START/STOP/SCL-edge
// strobes plus the synced SDA level aligned with those strobes.
module i2c_bus_sync
    import i2c_pkg::*;
(
    input  logic     i_clk,
    input  logic     reset,
    input  logic     scl_in,
    input  logic     sda_in,
    output bus_evt_t evt
);

    // [0],[1] form the 2-flop synchronizer; [2] is the previous synced value
    logic [2:0] scl_sr;
    logic [2:0] sda_sr;

    always_ff @(posedge i_clk or posedge reset) begin
        if (reset) begin
            scl_sr       <= '1;
            sda_sr       <= '1;
            evt.start    <= 1'b0;
            evt.stop     <= 1'b0;
            evt.scl_rise <= 1'b0;
            evt.scl_fall <= 1'b0;
            evt.sda      <= 1'b1;
        end else begin
            scl_sr       <= {scl_sr[1:0], scl_in};
            sda_sr       <= {sda_sr[1:0], sda_in};
            evt.start    <= scl_sr[1] & scl_sr[2] & sda_sr[2] & ~sda_sr[1];
            evt.stop     <= scl_sr[1] & scl_sr[2] & ~sda_sr[2] & sda_sr[1];
            evt.scl_rise <= scl_sr[1] & ~scl_sr[2];
            evt.scl_fall <= ~scl_sr[1] & scl_sr[2];
            evt.sda      <= sda_sr[1];
        end
    end

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target exposing a small register file: write = [addr+W][ptr][data...],
// read = [addr+R][data...]. Define I2C_TARGET_AUTOINC_EN to auto-increment ptr.
module i2c_target_regs
    import i2c_pkg::*;
#(
    parameter logic [6:0]  TARGET_ADDR = 7'h3C,
    parameter int unsigned NUM_REGS    = 4
) (
    input  logic                  i_clk,
    input  logic                  reset,
    input  logic                  scl_in,
    input  logic                  sda_in,
    output logic                  sda_out,
    output logic                  sda_out_en,
    output logic [NUM_REGS*8-1:0] reg_out,
    output logic                  wr_pulse,
    output logic                  busy
);

    localparam int unsigned PTR_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    bus_evt_t                evt;
    state_t                  state, state_nxt;
    logic [BIT_CNT_W-1:0]    bit_cnt, bit_cnt_nxt;
    logic [BYTE_W-1:0]       shreg, shreg_nxt;
    logic [BYTE_W-1:0]       rx_byte;
    logic                    rw_q, rw_nxt;
    logic                    mack_q, mack_nxt;
    logic [PTR_W-1:0]        ptr, ptr_nxt;
    logic [BYTE_W-1:0]       regs     [NUM_REGS];
    logic [BYTE_W-1:0]       regs_nxt [NUM_REGS];
    logic                    sda_oe_nxt, wr_nxt, busy_nxt;

    i2c_bus_sync u_sync (
        .i_clk  (i_clk),
        .reset  (reset),
        .scl_in (scl_in),
        .sda_in (sda_in),
        .evt    (evt)
    );

    function automatic logic [PTR_W-1:0] ptr_adv(input logic [PTR_W-1:0] p);
`ifdef I2C_TARGET_AUTOINC_EN
        return (p == PTR_W'(NUM_REGS - 1)) ? '0 : p + PTR_W'(1);
`else
        return p;
`endif
    endfunction

    assign rx_byte = {shreg[BYTE_W-2:0], evt.sda};
    assign sda_out = 1'b0;

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg_out
        assign reg_out[8*i +: 8] = regs[i];
    end

    always_ff @(posedge i_clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            rw_q       <= 1'b0;
            mack_q     <= 1'b0;
            ptr        <= '0;
            regs       <= '{default: '0};
            sda_out_en <= 1'b0;
            wr_pulse   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            bit_cnt    <= bit_cnt_nxt;
            shreg      <= shreg_nxt;
            rw_q       <= rw_nxt;
            mack_q     <= mack_nxt;
            ptr        <= ptr_nxt;
            regs       <= regs_nxt;
            sda_out_en <= sda_oe_nxt;
            wr_pulse   <= wr_nxt;
            busy       <= busy_nxt;
        end
    end

    // Bus conditions pre-empt any SCL edge seen in the same cycle
    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        shreg_nxt   = shreg;
        rw_nxt      = rw_q;
        mack_nxt    = mack_q;
        ptr_nxt     = ptr;
        regs_nxt    = regs;
        sda_oe_nxt  = sda_out_en;
        wr_nxt      = 1'b0;
        busy_nxt    = busy;

        if (evt.start) begin
            state_nxt   = ADDR;
            bit_cnt_nxt = '0;
            sda_oe_nxt  = 1'b0;
        end else if (evt.stop) begin
            state_nxt   = IDLE;
            bit_cnt_nxt = '0;
            sda_oe_nxt  = 1'b0;
            busy_nxt    = 1'b0;
        end else begin
            case (state)
                IDLE: ;

                ADDR: if (evt.scl_rise) begin
                    shreg_nxt   = rx_byte;
                    bit_cnt_nxt = bit_cnt + BIT_CNT_W'(1);
                    if (bit_cnt == BIT_CNT_W'(7)) begin
                        bit_cnt_nxt = '0;
                        if (rx_byte[ADDR_MSB:ADDR_LSB] == TARGET_ADDR) begin
                            state_nxt = ADDR_ACK;
                            rw_nxt    = rx_byte[RW_BIT];
                            busy_nxt  = 1'b1;
                        end else begin
                            state_nxt  = IDLE;
                            sda_oe_nxt = 1'b0;
                            busy_nxt   = 1'b0;
                        end
                    end
                end

                PTR, WDATA: if (evt.scl_rise) begin
                    shreg_nxt   = rx_byte;
                    bit_cnt_nxt = bit_cnt + BIT_CNT_W'(1);
                    if (bit_cnt == BIT_CNT_W'(7)) begin
                        bit_cnt_nxt = '0;
                        if (state == PTR) begin
                            ptr_nxt   = rx_byte[PTR_W-1:0];
                            state_nxt = PTR_ACK;
                        end else begin
                            state_nxt = WDATA_ACK;
                        end
                    end
                end

                // First SCL fall drives ACK; the fall ending the 9th clock hands over
                ADDR_ACK, PTR_ACK, WDATA_ACK: if (evt.scl_fall) begin
                    if (bit_cnt == '0) begin
                        sda_oe_nxt  = 1'b1;
                        bit_cnt_nxt = BIT_CNT_W'(1);
                    end else begin
                        bit_cnt_nxt = '0;
                        sda_oe_nxt  = 1'b0;
                        case (state)
                            ADDR_ACK: begin
                                if (rw_q) begin
                                    state_nxt  = RDATA;
                                    shreg_nxt  = regs[ptr];
                                    sda_oe_nxt = ~regs[ptr][BYTE_W-1];
                                end else begin
                                    state_nxt = PTR;
                                end
                            end
                            PTR_ACK: state_nxt = WDATA;
                            default: begin
                                regs_nxt[ptr] = shreg;
                                wr_nxt        = 1'b1;
                                ptr_nxt       = ptr_adv(ptr);
                                state_nxt     = WDATA;
                            end
                        endcase
                    end
                end

                RDATA: begin
                    if (evt.scl_rise) begin
                        bit_cnt_nxt = bit_cnt + BIT_CNT_W'(1);
                    end else if (evt.scl_fall) begin
                        if (bit_cnt == BIT_CNT_W'(8)) begin
                            sda_oe_nxt  = 1'b0;
                            bit_cnt_nxt = '0;
                            state_nxt   = RDATA_ACK;
                        end else begin
                            shreg_nxt  = {shreg[BYTE_W-2:0], 1'b0};
                            sda_oe_nxt = ~shreg[BYTE_W-2];
                        end
                    end
                end

                RDATA_ACK: begin
                    if (evt.scl_rise) begin
                        mack_nxt = (evt.sda == ACK_LVL);
                        ptr_nxt  = ptr_adv(ptr);
                    end else if (evt.scl_fall) begin
                        bit_cnt_nxt = '0;
                        if (mack_q) begin
                            state_nxt  = RDATA;
                            shreg_nxt  = regs[ptr];
                            sda_oe_nxt = ~regs[ptr][BYTE_W-1];
                        end else begin
                            state_nxt  = IDLE;
                            sda_oe_nxt = 1'b0;
                            busy_nxt   = 1'b0;
                        end
                    end
                end

                default: state_nxt = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_target_regs.sv
// Randomized bench for i2c_target_regs: a bit-banged bus master plus a
// transaction-level register/pointer model of the target.
module tb_i2c_target_regs;

    localparam logic [6:0] TADDR = 7'h3C;
    localparam int         NREG  = 4;
    localparam int         Q     = 6;

    logic              i_clk = 1'b0;
    logic              reset;
    logic              scl;
    logic              m_sda;
    logic              sda_bus;
    logic              sda_out;
    logic              sda_out_en;
    logic [NREG*8-1:0] reg_out;
    logic              wr_pulse;
    logic              busy;

    logic [7:0] mregs [NREG];
    int         mptr;
    logic [7:0] wdata [3];
    int         n_checks = 0;
    int         n_errs   = 0;
    int         wr_cnt   = 0;
    int         busy_cnt = 0;

    // Wired-AND open-drain bus
    assign sda_bus = m_sda & (sda_out_en ? sda_out : 1'b1);

    i2c_target_regs #(.TARGET_ADDR(TADDR), .NUM_REGS(NREG)) dut (
        .i_clk      (i_clk),
        .reset      (reset),
        .scl_in     (scl),
        .sda_in     (sda_bus),
        .sda_out    (sda_out),
        .sda_out_en (sda_out_en),
        .reg_out    (reg_out),
        .wr_pulse   (wr_pulse),
        .busy       (busy)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) begin
        if (wr_pulse) wr_cnt++;
        if (busy) busy_cnt++;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [NREG*8-1:0] model_flat();
        logic [NREG*8-1:0] f;
        for (int i = 0; i < NREG; i++) f[8*i +: 8] = mregs[i];
        return f;
    endfunction

    task automatic model_adv();
`ifdef I2C_TARGET_AUTOINC_EN
        mptr = (mptr + 1) % NREG;
`endif
    endtask

    task automatic wait_q();
        repeat (Q) @(negedge i_clk);
    endtask

    task automatic bus_start();
        m_sda = 1'b1; wait_q();
        scl   = 1'b1; wait_q();
        m_sda = 1'b0; wait_q();
        scl   = 1'b0; wait_q();
    endtask

    task automatic bus_stop();
        m_sda = 1'b0; wait_q();
        scl   = 1'b1; wait_q();
        m_sda = 1'b1; wait_q();
    endtask

    task automatic send_bit(input logic b);
        m_sda = b;    wait_q();
        scl   = 1'b1; wait_q(); wait_q();
        scl   = 1'b0; wait_q();
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        m_sda = 1'b1; wait_q();
        scl   = 1'b1; wait_q();
        ack   = sda_bus; wait_q();
        scl   = 1'b0; wait_q();
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            m_sda = 1'b1; wait_q();
            scl   = 1'b1; wait_q();
            b[i]  = sda_bus; wait_q();
            scl   = 1'b0; wait_q();
        end
        send_bit(nack);
        m_sda = 1'b1;
    endtask

    task automatic write_txn(input logic [7:0] p, input int n);
        logic ack;
        int   w0;
        w0 = wr_cnt;
        bus_start();
        write_byte({TADDR, 1'b0}, ack);
        check_eq("w_addr_ack", ack, 1'b0);
        check_eq("w_busy", busy, 1'b1);
        write_byte(p, ack);
        check_eq("w_ptr_ack", ack, 1'b0);
        mptr = int'(p) % NREG;
        for (int i = 0; i < n; i++) begin
            write_byte(wdata[i], ack);
            check_eq("w_data_ack", ack, 1'b0);
            mregs[mptr] = wdata[i];
            model_adv();
        end
        bus_stop();
        check_eq("w_busy_end", busy, 1'b0);
        check_eq("w_regs", reg_out, model_flat());
        check_eq("w_pulses", 64'(wr_cnt - w0), 64'(n));
    endtask

    task automatic read_txn(input logic [7:0] p, input int n);
        logic       ack;
        logic [7:0] b;
        bus_start();
        write_byte({TADDR, 1'b0}, ack);
        check_eq("r_waddr_ack", ack, 1'b0);
        write_byte(p, ack);
        check_eq("r_ptr_ack", ack, 1'b0);
        mptr = int'(p) % NREG;
        bus_start();
        write_byte({TADDR, 1'b1}, ack);
        check_eq("r_raddr_ack", ack, 1'b0);
        for (int i = 0; i < n; i++) begin
            read_byte(i == n - 1, b);
            check_eq("r_data", b, mregs[mptr]);
            model_adv();
        end
        bus_stop();
        check_eq("r_busy_end", busy, 1'b0);
        check_eq("r_sda_rel", sda_out_en, 1'b0);
    endtask

    initial begin
        logic       ack;
        int         b0, w0;
        logic [7:0] p;

        for (int i = 0; i < NREG; i++) mregs[i] = 8'h00;
        mptr  = 0;
        reset = 1'b1;
        scl   = 1'b1;
        m_sda = 1'b1;
        repeat (4) @(negedge i_clk);
        check_eq("rst_sda_oe", sda_out_en, 1'b0);
        check_eq("rst_sda_out", sda_out, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_wr", wr_pulse, 1'b0);
        check_eq("rst_regs", reg_out, model_flat());
        reset = 1'b0;
        repeat (4) @(negedge i_clk);

        // Single write to reg[1]
        wdata[0] = 8'hA5;
        write_txn(8'h01, 1);

        // Seed reg[3]/reg[0], then set ptr 3 and read two bytes after repeated START
        wdata[0] = 8'h5C;
        write_txn(8'h03, 1);
        wdata[0] = 8'hC3;
        write_txn(8'h00, 1);
        read_txn(8'h03, 2);

        // Wrong address is ignored entirely
        b0 = busy_cnt;
        w0 = wr_cnt;
        bus_start();
        write_byte({7'h3D, 1'b0}, ack);
        check_eq("bad_addr_nack", ack, 1'b1);
        write_byte(8'h01, ack);
        check_eq("bad_ptr_nack", ack, 1'b1);
        write_byte(8'h77, ack);
        check_eq("bad_data_nack", ack, 1'b1);
        bus_stop();
        check_eq("bad_busy", 64'(busy_cnt - b0), 64'd0);
        check_eq("bad_regs", reg_out, model_flat());
        check_eq("bad_pulses", 64'(wr_cnt - w0), 64'd0);

        // STOP after 4 data bits aborts the byte
        w0 = wr_cnt;
        bus_start();
        write_byte({TADDR, 1'b0}, ack);
        check_eq("abort_addr_ack", ack, 1'b0);
        write_byte(8'h02, ack);
        check_eq("abort_ptr_ack", ack, 1'b0);
        mptr = 2;
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        bus_stop();
        check_eq("abort_busy", busy, 1'b0);
        check_eq("abort_regs", reg_out, model_flat());
        check_eq("abort_pulses", 64'(wr_cnt - w0), 64'd0);

        // Pointer 5 folds to reg[1]
        wdata[0] = 8'h96;
        write_txn(8'h05, 1);

        // Reset while the target pulls SDA low for a 0 data bit
        wdata[0] = 8'h35;
        write_txn(8'h02, 1);
        bus_start();
        write_byte({TADDR, 1'b0}, ack);
        write_byte(8'h02, ack);
        bus_start();
        write_byte({TADDR, 1'b1}, ack);
        check_eq("rr_addr_ack", ack, 1'b0);
        check_eq("rr_drive_low", sda_out_en, 1'b1);
        reset = 1'b1;
        #1;
        check_eq("rr_sda_rel", sda_out_en, 1'b0);
        check_eq("rr_regs", reg_out, 64'd0);
        check_eq("rr_busy", busy, 1'b0);
        for (int i = 0; i < NREG; i++) mregs[i] = 8'h00;
        mptr = 0;
        repeat (3) @(negedge i_clk);
        reset = 1'b0;
        b0 = busy_cnt;
        for (int i = 0; i < 5; i++) begin
            m_sda = 1'b1; wait_q();
            scl   = 1'b1; wait_q();
            check_eq("rr_ignore_sda", sda_out_en, 1'b0);
            wait_q();
            scl   = 1'b0; wait_q();
        end
        bus_stop();
        check_eq("rr_ignore_busy", 64'(busy_cnt - b0), 64'd0);

        // Random mix of writes and reads
        for (int t = 0; t < 16; t++) begin
            p = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i < 3; i++) wdata[i] = 8'($urandom);
                write_txn(p, $urandom_range(1, 3));
            end else begin
                read_txn(p, $urandom_range(1, 3));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
